uart_tx_frame: RTL

Parametrised UART transmit engine, successor to the fixed 8N1 transmitter. It adds a byte FIFO with a valid/ready handshake, selectable parity, 1 or 2 stop bits, and 5–9 data bits. It sits between CPU/MMIO store logic and the board TX pin, and it continues the same frame without a gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 88 ++++++++
 rtl/uart_tx_frame.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive blocks:
//   - parity encodings (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - transmit FSM state type (tx_state_e)
//   - calc_clks_per_bit(): clock cycles per bit cell, truncated division
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // ST_BREAK and ST_GAP are only reachable when the line-break option is built.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5,
        ST_GAP    = 3'd6
    } tx_state_e;

    // Integer, truncated. Callers must keep the result >= 2.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with registered full/empty flags.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   i_push          : write request; ignored while full
//   i_push_data     : word written on an accepted push
//   i_pop           : read request; ignored while empty
//   o_rd_data       : head entry (valid while !o_empty)
//   o_full, o_empty : registered status flags
//   o_count         : entries currently stored
// Push and pop in the same cycle leave the count unchanged. Pointers wrap
// naturally because FIFO_DEPTH is a power of two.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_push_data,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_rd_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [CNT_W-1:0]     o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic                 r_empty;

    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter: byte FIFO, 5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits. Frames queued in the FIFO go out back to back.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low
//   tx_data     : word to send, LSB first on the line
//   tx_valid    : producer offers tx_data
//   tx_ready    : FIFO not full
//   tx_break    : (UART_TX_BREAK_EN only) hold the line low while idle
//   tx          : serial line, idle high, driven from a flop
//   tx_busy     : FSM outside IDLE
//   tx_done     : one-cycle pulse at the edge where the last stop bit ends
//   fifo_count  : entries queued
//   o_dbg_state : current FSM state
//
// Handshake: a word is transferred on every rising clk edge where
// tx_valid && tx_ready; tx_data is captured only then. tx_valid may be held
// high across cycles; each edge with tx_ready high takes one word.
//
// Build option: define UART_TX_BREAK_EN to add the tx_break input and the
// break/guard-gap states. Without it no break logic exists.
//
// Timing: the pin register follows the FSM state by one cycle, so a word
// accepted at edge N is popped at N+1 and the start bit appears at N+2.
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              tx_data,
    input  logic                              tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                              tx_break,
`endif
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output tx_state_e                         o_dbg_state
);

    localparam int  CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int  CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int  BIT_W        = 4;
    localparam bit  PAR_EN       = (PARITY != PARITY_NONE);
    localparam bit  PAR_ODD      = (PARITY == PARITY_ODD);

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [CNT_W-1:0]     w_clk_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_done_q;
    logic                 r_done;
    logic                 w_done_ev;
    logic                 w_pop;
    logic                 w_shift_en;
    logic                 w_cell_end;

    logic [DATA_BITS-1:0] w_fifo_rd_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (fifo_count)
    );

    assign w_cell_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Next state, counters, and the value the pin takes at the next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        w_done_ev   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_nxt = '0;
                w_bit_nxt = '0;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_BREAK;
                end else
`endif
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_cell_end) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_cell_end) begin
                    w_clk_nxt  = '0;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end

            ST_PARITY: begin
                w_tx_nxt = r_par;
                if (w_cell_end) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_cell_end) begin
                    w_clk_nxt = '0;
                    if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        // Last stop cycle: chain straight into the next frame
                        // when data is waiting, so no idle cell is inserted.
                        w_done_ev   = 1'b1;
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_IDLE;
`ifdef UART_TX_BREAK_EN
                        if (tx_break) begin
                            w_state_nxt = ST_BREAK;
                        end else
`endif
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_START;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end

`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                w_tx_nxt  = !tx_break;
                w_clk_nxt = '0;
                if (!tx_break) begin
                    // The release cycle already shows tx=1, so it counts as
                    // the first cycle of the guard cell.
                    w_clk_nxt   = CNT_W'(1);
                    w_state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                w_tx_nxt = 1'b1;
                if (tx_break) begin
                    w_tx_nxt    = 1'b0;
                    w_clk_nxt   = '0;
                    w_state_nxt = ST_BREAK;
                end else if (w_cell_end) begin
                    w_clk_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_clk_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_done_q  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            // Two stages so the pulse lines up with the pin, which itself
            // trails the state by one cycle.
            r_done_q  <= w_done_ev;
            r_done    <= r_done_q;
            if (w_pop) begin
                r_shift <= w_fifo_rd_data;
                r_par   <= (^w_fifo_rd_data) ^ PAR_ODD;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign tx          = r_tx;
    assign tx_ready    = !w_fifo_full;
    assign tx_busy     = (r_state != ST_IDLE);
    assign tx_done     = r_done;
    assign o_dbg_state = r_state;

endmodule
